hpdcache_sram_rmw_ctrl: RTL and testbench
=========================================

Name: hpdcache_sram_rmw_ctrl

Overview:
Read-modify-write front-end that sits directly upstream of the hpdcache 1RW SRAM wrapper. It gives the cache a byte-enabled 1RW port when the underlying macro supports only full-word writes. Partial writes are converted into an SRAM read followed by a merged full-word write. Reads and full-mask writes pass straight through.

Parameters:
ADDR_SIZE, 8, SRAM word address width
DATA_SIZE, 32, SRAM word width in bits; must be a multiple of 8 (elaboration-time assertion)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_SIZE  word address
req_wdata  in  DATA_SIZE  write data
req_wbyteenable  in  DATA_SIZE/8  per-byte write enable (bit i covers wdata[8i+7:8i])
rsp_valid  out  1  read data valid (one-cycle pulse)
rsp_rdata  out  DATA_SIZE  read data, meaningful only when rsp_valid=1
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_SIZE  SRAM address
sram_wdata  out  DATA_SIZE  SRAM full-word write data
sram_rdata  in  DATA_SIZE  SRAM read data, valid the cycle after a read (cs=1, we=0)

Behaviour:
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - No skid buffer; req_* must be held stable while req_valid=1 && req_ready=0.
- FSM states:
  - IDLE: req_ready=1.
  - RMW_WR: req_ready=0.
- Accepted read in IDLE:
  - Drive sram_cs=1, sram_we=0, sram_addr=req_addr combinationally.
  - rsp_valid=1 exactly one cycle later; rsp_rdata=sram_rdata (combinational pass-through).
  - Back-to-back reads sustain one per cycle.
- Accepted write with wbyteenable all ones:
  - Drive sram_cs=1, sram_we=1, sram_addr=req_addr, sram_wdata=req_wdata in the same cycle.
  - No rsp_valid; stay in IDLE.
- Accepted write with wbyteenable all zeros:
  - No SRAM access (sram_cs=0), no response; stay in IDLE.
- Accepted partial write (mask neither all 0 nor all 1):
  - Cycle 0:
    - Drive an SRAM read of req_addr.
    - Register addr, wdata and mask into a pending buffer.
    - Go to RMW_WR.
  - Cycle 1 (RMW_WR):
    - sram_cs=1, sram_we=1, sram_addr=pending addr.
    - sram_wdata byte i = mask[i] ? pending wdata byte i : sram_rdata byte i.
    - Return to IDLE.
    - No rsp_valid for this internal read.
  - Throughput: partial writes occupy 2 cycles.
  - A request following a partial write is accepted in cycle 2 at the earliest and observes the merged data.
- rsp_valid is a registered flag: set on an accepted read, cleared otherwise.
- When idle with no accepted request, sram_cs=0. The sram_we, sram_addr and sram_wdata values are don't-care when sram_cs=0.
- Reset:
  - While rst=1: sram_cs=0, req_ready=0, rsp_valid=0. Outputs are gated, so a merge write in RMW_WR during reset is suppressed.
  - After reset: state=IDLE, pending buffer cleared to 0, rsp_valid=0.
  - req_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation:
  - rst in RMW_WR aborts the merge; the target word is left unmodified.
  - rst on the cycle after a read drops that response (rsp_valid=0).
- No address hazards arise because the FSM serialises partial writes; no bypass logic is present.

Test Plan:
- Full write addr 0x10 data 0xDEADBEEF mask 0xF, then read 0x10 → sram_we=1 the same cycle; read gives rsp_valid one cycle later with 0xDEADBEEF.
- Preload 0x20=0x11223344; partial write data 0xAABBCCDD mask 0x5 → req_ready=0 for one cycle; RMW_WR sram_wdata=0x11BB33DD; a later read returns 0x11BB33DD.
- Back-to-back partial writes to 0x30 (mask 0x1 data 0x000000AA, then mask 0x8 data 0xCC000000) on a word holding 0 → final word 0xCC0000AA; second write is accepted 2 cycles after the first.
- Write with mask 0x0 to 0x40 (holding 0x12345678) → sram_cs=0 that cycle; a later read returns 0x12345678.
- Read stream to 0x00..0x07 with req_valid held high → eight consecutive rsp_valid pulses, with data in address order.
- Assert rst during RMW_WR of a partial write to 0x50 (holding 0xFFFFFFFF) → sram_cs=0 in that cycle, req_ready=1 on the first cycle after reset, 0x50 still reads 0xFFFFFFFF.

Source files
------------

// File: rtl/hpdcache_sram_rmw_ctrl.sv
// hpdcache_sram_rmw_ctrl: byte-enabled 1RW front-end for a full-word SRAM.
// Partial writes become an SRAM read followed by a merged full-word write.
module hpdcache_sram_rmw_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_SIZE-1:0]   req_addr,
    input  logic [DATA_SIZE-1:0]   req_wdata,
    input  logic [DATA_SIZE/8-1:0] req_wbyteenable,
    output logic                   rsp_valid,
    output logic [DATA_SIZE-1:0]   rsp_rdata,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [ADDR_SIZE-1:0]   sram_addr,
    output logic [DATA_SIZE-1:0]   sram_wdata,
    input  logic [DATA_SIZE-1:0]   sram_rdata
);
    localparam int BE_SIZE = DATA_SIZE / 8;

    if (DATA_SIZE % 8 != 0) begin : g_data_size_chk
        $error("DATA_SIZE must be a multiple of 8");
    end

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_SIZE-1:0] pend_wdata_q, pend_wdata_d;
    logic [BE_SIZE-1:0]   pend_be_q, pend_be_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 accept;
    logic                 be_full;
    logic                 be_none;
    logic [DATA_SIZE-1:0] merged;

    assign be_full   = &req_wbyteenable;
    assign be_none   = ~|req_wbyteenable;
    assign req_ready = !rst && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_rdata = sram_rdata;
    // A response due in a reset cycle is dropped.
    assign rsp_valid = rsp_valid_q && !rst;

    always_comb begin
        merged = sram_rdata;
        for (int i = 0; i < BE_SIZE; i++) begin
            if (pend_be_q[i]) begin
                merged[8*i +: 8] = pend_wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_be_d    = pend_be_q;
        rsp_valid_d  = accept && !req_we;
        sram_cs      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = req_addr;
        sram_wdata   = req_wdata;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_we) begin
                        sram_cs = 1'b1;
                    end else if (be_full) begin
                        sram_cs = 1'b1;
                        sram_we = 1'b1;
                    end else if (!be_none) begin
                        sram_cs      = 1'b1;
                        pend_addr_d  = req_addr;
                        pend_wdata_d = req_wdata;
                        pend_be_d    = req_wbyteenable;
                        state_d      = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                sram_cs    = !rst;
                sram_we    = 1'b1;
                sram_addr  = pend_addr_q;
                sram_wdata = merged;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_be_q    <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_be_q    <= pend_be_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_hpdcache_sram_rmw_ctrl.sv
// Bench for hpdcache_sram_rmw_ctrl: SRAM model, transaction-level golden
// memory model checked every cycle, plus directed literal expectations.
module tb_hpdcache_sram_rmw_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wbyteenable;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        sram_cs, sram_we;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    hpdcache_sram_rmw_ctrl #(.ADDR_SIZE(8), .DATA_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wbyteenable(req_wbyteenable),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Full-word-only SRAM macro: one-cycle read latency.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Golden memory and expected per-cycle behaviour.
    logic [31:0] gold [0:255];
    logic        e_rv = 1'b0, n_rv;
    logic [31:0] e_rd = '0, n_rd;
    logic        m_pend = 1'b0, n_pend;
    logic [7:0]  m_addr = '0, n_addr;
    logic [31:0] m_word = '0, n_word;
    logic [31:0] rq [$];
    int          rc [$];

    always @(negedge clk) begin
        chk("req_ready", req_ready, !rst && !m_pend);
        chk("rsp_valid", rsp_valid, e_rv && !rst);
        if (rsp_valid && e_rv && !rst) chk("rsp_rdata", rsp_rdata, e_rd);
        if (rsp_valid) begin
            rq.push_back(rsp_rdata);
            rc.push_back(cyc);
        end
        n_rv = 1'b0; n_rd = '0;
        n_pend = 1'b0; n_addr = '0; n_word = '0;
        if (m_pend) begin
            chk("merge_cs", sram_cs, !rst);
            if (!rst) begin
                chk("merge_we", sram_we, 1);
                chk("merge_addr", sram_addr, m_addr);
                chk("merge_wdata", sram_wdata, m_word);
                gold[m_addr] = m_word;
            end
        end else if (rst || !req_valid) begin
            chk("idle_cs", sram_cs, 0);
        end else if (!req_we) begin
            chk("rd_cs", sram_cs, 1);
            chk("rd_we", sram_we, 0);
            chk("rd_addr", sram_addr, req_addr);
            n_rv = 1'b1;
            n_rd = gold[req_addr];
        end else if (req_wbyteenable == 4'hF) begin
            chk("fw_cs", sram_cs, 1);
            chk("fw_we", sram_we, 1);
            chk("fw_addr", sram_addr, req_addr);
            chk("fw_wdata", sram_wdata, req_wdata);
            gold[req_addr] = req_wdata;
        end else if (req_wbyteenable == 4'h0) begin
            chk("zw_cs", sram_cs, 0);
        end else begin
            chk("pw_cs", sram_cs, 1);
            chk("pw_we", sram_we, 0);
            chk("pw_addr", sram_addr, req_addr);
            n_pend = 1'b1;
            n_addr = req_addr;
            n_word = mrg(gold[req_addr], req_wdata, req_wbyteenable);
        end
        e_rv = n_rv; e_rd = n_rd;
        m_pend = n_pend; m_addr = n_addr; m_word = n_word;
    end

    task automatic req(input logic we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output int acyc, output logic acs,
                       output logic awe);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a;
        req_wdata = d; req_wbyteenable = be;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) chk("req_timeout", req_ready, 1);
        acyc = cyc; acs = sram_cs; awe = sram_we;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] a,
                      input logic [31:0] exp);
        int c; logic s, w;
        req(1'b0, a, 32'h0, 4'h0, c, s, w);
        @(negedge clk);
        chk({name, "_v"}, rsp_valid, 1);
        chk(name, rsp_rdata, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        logic s, w;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            gold[i] = '0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wbyteenable = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);
        @(posedge clk); #1;

        req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, t1, s, w);
        chk("full_cs", s, 1);
        chk("full_we", w, 1);
        rd("full_rd", 8'h10, 32'hDEADBEEF);

        req(1'b1, 8'h20, 32'h11223344, 4'hF, t1, s, w);
        req(1'b1, 8'h20, 32'hAABBCCDD, 4'h5, t1, s, w);
        chk("part_cs0", s, 1);
        chk("part_we0", w, 0);
        @(negedge clk);
        chk("part_busy", req_ready, 0);
        chk("part_merge_we", sram_we, 1);
        chk("part_merge", sram_wdata, 32'h11BB33DD);
        @(posedge clk); #1;
        rd("part_rd", 8'h20, 32'h11BB33DD);

        req(1'b1, 8'h30, 32'h000000AA, 4'h1, t1, s, w);
        req(1'b1, 8'h30, 32'hCC000000, 4'h8, t2, s, w);
        chk("b2b_gap", t2 - t1, 2);
        @(posedge clk); #1;
        rd("b2b_rd", 8'h30, 32'hCC0000AA);

        req(1'b1, 8'h40, 32'h12345678, 4'hF, t1, s, w);
        req(1'b1, 8'h40, 32'h9ABCDEF0, 4'h0, t1, s, w);
        chk("zero_cs", s, 0);
        rd("zero_rd", 8'h40, 32'h12345678);

        for (int i = 0; i < 8; i++)
            req(1'b1, i[7:0], 32'hC0DE0000 | i, 4'hF, t1, s, w);
        rq.delete(); rc.delete();
        for (int i = 0; i < 8; i++)
            req(1'b0, i[7:0], 32'h0, 4'h0, t1, s, w);
        @(negedge clk);
        @(posedge clk); #1;
        chk("stream_cnt", rq.size(), 8);
        for (int i = 0; i < rq.size() && i < 8; i++) begin
            chk("stream_data", rq[i], 32'hC0DE0000 | i);
            if (i > 0) chk("stream_gap", rc[i] - rc[i-1], 1);
        end

        req(1'b1, 8'h50, 32'hFFFFFFFF, 4'hF, t1, s, w);
        req(1'b1, 8'h50, 32'h00000000, 4'h3, t1, s, w);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_merge_cs", sram_cs, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        @(posedge clk); #1;
        rd("rst_rd", 8'h50, 32'hFFFFFFFF);

        req(1'b0, 8'h10, 32'h0, 4'h0, t1, s, w);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_rsp", rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        rd("post_rst_rd", 8'h10, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
